// File: rtl/divyasree_thermo_encoder_pipe.sv
// Thermometer-to-binary encoder: capture stage, bubble-corrected priority encode,
// and a power-of-two window averager on the encoded codes.
module divyasree_thermo_encoder_pipe #(
  parameter int N_BITS   = 4,
  parameter int AVG_LOG2 = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2**N_BITS-2:0]  therm,
  output logic [N_BITS-1:0]     code,
  output logic                  code_valid,
  output logic                  ovr,
  output logic                  bubble_err,
  output logic [N_BITS-1:0]     avg_code,
  output logic                  avg_valid
);

  localparam int M  = 2**N_BITS - 1;
  localparam int AW = N_BITS + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [M-1:0]      t1_r;
  logic              v1_r;
  logic [M+1:0]      ext_s;
  logic [M-1:0]      corr_s;
  logic [N_BITS-1:0] enc_s;
  logic              seen_s;
  logic              berr_s;
  logic [N_BITS-1:0] code_r;
  logic              code_valid_r;
  logic              ovr_r;
  logic              bubble_err_r;
  logic [AW-1:0]     acc_r;
  logic [AW-1:0]     sum_s;
  logic [CW-1:0]     cnt_r;
  logic              win_last_s;
  logic [N_BITS-1:0] avg_code_r;
  logic              avg_valid_r;

  // Capture stage: sample the comparator bank when en marks it valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_r <= {M{1'b0}};
      v1_r <= 1'b0;
    end else begin
      v1_r <= en;
      if (en) begin
        t1_r <= therm;
      end else begin
        t1_r <= t1_r;
      end
    end
  end

  // Bubble correction (3-input majority, padded 1 below / 0 above) and priority encode.
  always_comb begin
    ext_s  = {1'b0, t1_r, 1'b1};
    corr_s = {M{1'b0}};
    enc_s  = {N_BITS{1'b0}};
    for (int k = 0; k < M; k++) begin
      corr_s[k] = maj3(ext_s[k], ext_s[k+1], ext_s[k+2]);
    end
    for (int k = 0; k < M; k++) begin
      if (corr_s[k]) begin
        enc_s = N_BITS'(k + 1);
      end else begin
        enc_s = enc_s;
      end
    end
  end

  // Raw-sample bubble detect: any zero sitting below a one.
  always_comb begin
    seen_s = 1'b0;
    berr_s = 1'b0;
    for (int k = M - 1; k >= 0; k--) begin
      if (t1_r[k]) begin
        seen_s = 1'b1;
      end else if (seen_s) begin
        berr_s = 1'b1;
      end else begin
        berr_s = berr_s;
      end
    end
  end

  // Encode stage: results update only when a valid sample completes, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r       <= {N_BITS{1'b0}};
      code_valid_r <= 1'b0;
      ovr_r        <= 1'b0;
      bubble_err_r <= 1'b0;
    end else begin
      code_valid_r <= v1_r;
      if (v1_r) begin
        code_r       <= enc_s;
        ovr_r        <= (enc_s == {N_BITS{1'b1}});
        bubble_err_r <= berr_s;
      end else begin
        code_r       <= code_r;
        ovr_r        <= ovr_r;
        bubble_err_r <= bubble_err_r;
      end
    end
  end

  assign sum_s      = acc_r + AW'(code_r);
  assign win_last_s = (AVG_LOG2 == 0) || (cnt_r == {CW{1'b1}});

  // Window averager: counts code_valid strobes; the sum never exceeds AW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      avg_code_r  <= {N_BITS{1'b0}};
      avg_valid_r <= 1'b0;
    end else if (code_valid_r) begin
      if (win_last_s) begin
        avg_code_r  <= sum_s[AVG_LOG2 +: N_BITS];
        avg_valid_r <= 1'b1;
        acc_r       <= {AW{1'b0}};
        cnt_r       <= {CW{1'b0}};
      end else begin
        avg_code_r  <= avg_code_r;
        avg_valid_r <= 1'b0;
        acc_r       <= sum_s;
        cnt_r       <= cnt_r + CW'(1'b1);
      end
    end else begin
      avg_code_r  <= avg_code_r;
      avg_valid_r <= 1'b0;
      acc_r       <= acc_r;
      cnt_r       <= cnt_r;
    end
  end

  assign code       = code_r;
  assign code_valid = code_valid_r;
  assign ovr        = ovr_r;
  assign bubble_err = bubble_err_r;
  assign avg_code   = avg_code_r;
  assign avg_valid  = avg_valid_r;

endmodule

// File: tb/tb_divyasree_thermo_encoder_pipe.sv
// Bench: two encoder instances (window 1 and window 4) driven by the same stimulus,
// checked against a per-cycle reference model written from the encoding rules.
module tb_divyasree_thermo_encoder_pipe;

  logic        clk;
  logic        rst;
  logic        en;
  logic [14:0] therm;
  logic [3:0]  code0, code2, avg0, avg2;
  logic        cv0, cv2, ovr0, ovr2, be0, be2, avv0, avv2;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  logic        p_en;
  logic [14:0] p_th;
  logic [3:0]  m_code, m_avg0, m_avg2;
  logic        m_cv, m_ovr, m_be, m_av0, m_av2;
  int          m_sum, m_n;

  divyasree_thermo_encoder_pipe #(.N_BITS(4), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .therm(therm),
    .code(code0), .code_valid(cv0), .ovr(ovr0), .bubble_err(be0),
    .avg_code(avg0), .avg_valid(avv0));

  divyasree_thermo_encoder_pipe #(.N_BITS(4), .AVG_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .therm(therm),
    .code(code2), .code_valid(cv2), .ovr(ovr2), .bubble_err(be2),
    .avg_code(avg2), .avg_valid(avv2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] mk(input int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[14:0];
  endfunction

  // Highest position whose three-bit neighbourhood votes 1, plus one.
  function automatic int ref_code(input logic [14:0] th);
    int best = 0;
    for (int k = 0; k < 15; k++) begin
      int lo = (k == 0) ? 1 : int'(th[k-1]);
      int hi = (k == 14) ? 0 : int'(th[k+1]);
      if (lo + int'(th[k]) + hi >= 2) best = k + 1;
    end
    return best;
  endfunction

  // Clean thermometer codes are exactly 2^ones - 1.
  function automatic logic ref_bubble(input logic [14:0] th);
    int p = 0;
    for (int k = 0; k < 15; k++) p += int'(th[k]);
    return int'(th) != ((1 << p) - 1);
  endfunction

  task automatic model_reset();
    p_en = 1'b0; p_th = 15'h0000;
    m_code = 4'd0; m_cv = 1'b0; m_ovr = 1'b0; m_be = 1'b0;
    m_avg0 = 4'd0; m_avg2 = 4'd0; m_av0 = 1'b0; m_av2 = 1'b0;
    m_sum = 0; m_n = 0;
  endtask

  // One clock: apply inputs, advance past the edge, advance the model by one cycle.
  task automatic step(input logic e, input logic [14:0] th);
    en = e; therm = th;
    @(posedge clk); #1;
    m_av0 = 1'b0; m_av2 = 1'b0;
    if (m_cv) begin
      m_avg0 = m_code; m_av0 = 1'b1;
      m_sum += int'(m_code); m_n++;
      if (m_n == 4) begin
        m_avg2 = 4'(m_sum / 4); m_av2 = 1'b1; m_sum = 0; m_n = 0;
      end
    end
    m_cv = p_en;
    if (p_en) begin
      m_code = 4'(ref_code(p_th));
      m_ovr  = (m_code == 4'd15);
      m_be   = ref_bubble(p_th);
    end
    p_en = e; p_th = th;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; therm = 15'h0000;
    #3;
    nvec++;
    if ({code0, cv0, ovr0, be0, avg0, avv0, code2, cv2, ovr2, be2, avg2, avv2} !== 24'h000000) begin
      nerr++;
      $display("FAIL reset_state: got %h expected 000000",
               {code0, cv0, ovr0, be0, avg0, avv0, code2, cv2, ovr2, be2, avg2, avv2});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_directed();
    step(1'b1, 15'h007F);
    step(1'b0, 15'h0000);
    nvec++;
    if ({code0, cv0, ovr0, be0} !== {4'd7, 1'b1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL code_7f: got %h expected 7 1 0 0", {code0, cv0, ovr0, be0});
    end
    step(1'b0, 15'h0000);
    nvec++;
    if ({code0, cv0} !== {4'd7, 1'b0}) begin
      nerr++; $display("FAIL hold_after_strobe: got %h expected 7 0", {code0, cv0});
    end
    step(1'b1, 15'h7FFF);
    step(1'b1, 15'h0000);
    nvec++;
    if ({code0, cv0, ovr0, code2, ovr2} !== {4'd15, 1'b1, 1'b1, 4'd15, 1'b1}) begin
      nerr++; $display("FAIL full_scale: got %h expected f 1 1 f 1", {code0, cv0, ovr0, code2, ovr2});
    end
    step(1'b1, 15'h00BF);
    nvec++;
    if ({code0, cv0, ovr0, be0} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL zero_scale: got %h expected 0 1 0 0", {code0, cv0, ovr0, be0});
    end
    step(1'b0, 15'h0000);
    nvec++;
    if ({code0, cv0, ovr0, be0} !== {4'd7, 1'b1, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL bubble_bf: got %h expected 7 1 0 1", {code0, cv0, ovr0, be0});
    end
  endtask

  task automatic test_avg_window();
    int codes[4] = '{4, 5, 6, 8};
    int pulses = 0;
    logic [3:0] seen = 4'd0;
    rst = 1'b1; #1; @(posedge clk); #1; rst = 1'b0; model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(codes[i]));
      for (int j = 0; j < 3; j++) begin
        if (avv2) begin pulses++; seen = avg2; end
        if (i < 3 || j == 0) begin
          nvec++;
          if (avv2 !== 1'b0) begin
            nerr++; $display("FAIL avg_early: got avg_valid=%b at sample %0d expected 0", avv2, i);
          end
        end
        step(1'b0, 15'h0000);
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (avv2) begin pulses++; seen = avg2; end
      step(1'b0, 15'h0000);
    end
    nvec++;
    if (pulses != 1 || seen !== 4'd5) begin
      nerr++; $display("FAIL avg_window: got %0d pulses avg=%0d expected 1 pulse avg=5", pulses, seen);
    end
    nvec++;
    if ({avg2, avv2} !== {4'd5, 1'b0}) begin
      nerr++; $display("FAIL avg_hold: got %h expected 5 0", {avg2, avv2});
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [3:0] seen = 4'd0;
    step(1'b1, mk(9));
    step(1'b1, mk(10));
    step(1'b1, mk(11));
    rst = 1'b1; en = 1'b1; therm = mk(12);
    #1;
    nvec++;
    if ({code0, cv0, ovr0, be0, avg0, avv0, code2, cv2, ovr2, be2, avg2, avv2} !== 24'h000000) begin
      nerr++; $display("FAIL reset_async: got %h expected 000000",
                       {code0, cv0, ovr0, be0, avg0, avv0, code2, cv2, ovr2, be2, avg2, avv2});
    end
    @(posedge clk); #1;
    nvec++;
    if ({code0, cv0, code2, cv2, avg2, avv2} !== 16'h0000) begin
      nerr++; $display("FAIL reset_held: got %h expected 0000", {code0, cv0, code2, cv2, avg2, avv2});
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk(3));
    nvec++;
    if ({code0, cv0} !== {4'd3, 1'b1}) begin
      nerr++; $display("FAIL post_reset_first: got %h expected 3 1", {code0, cv0});
    end
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 15'h0000);
      if (avv2) begin pulses++; seen = avg2; end
    end
    nvec++;
    if (pulses != 1 || seen !== 4'd3) begin
      nerr++; $display("FAIL reset_new_window: got %0d pulses avg=%0d expected 1 pulse avg=3", pulses, seen);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, mk(i));
      if (i > 0) begin
        nvec++;
        if ({code0, cv0} !== {4'(i - 1), 1'b1}) begin
          nerr++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, {code0, cv0}, {4'(i - 1), 1'b1});
        end
      end
    end
    step(1'b0, 15'h0000);
    nvec++;
    if ({code0, cv0, ovr0} !== {4'd15, 1'b1, 1'b1}) begin
      nerr++; $display("FAIL back_to_back_last: got %h expected f 1 1", {code0, cv0, ovr0});
    end
  endtask

  task automatic test_random();
    logic [14:0] th;
    logic        e;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       th = mk($urandom_range(0, 15));
        1:       th = mk($urandom_range(0, 15)) ^ (15'h0001 << $urandom_range(0, 14));
        default: th = 15'($urandom);
      endcase
      e = ($urandom_range(0, 3) != 0);
      step(e, th);
      nvec++;
      if ({code0, cv0, ovr0, be0, avg0, avv0} !== {m_code, m_cv, m_ovr, m_be, m_avg0, m_av0}) begin
        nerr++; $display("FAIL random_w1[%0d]: got %h expected %h", i,
                         {code0, cv0, ovr0, be0, avg0, avv0}, {m_code, m_cv, m_ovr, m_be, m_avg0, m_av0});
      end
      nvec++;
      if ({code2, cv2, ovr2, be2, avg2, avv2} !== {m_code, m_cv, m_ovr, m_be, m_avg2, m_av2}) begin
        nerr++; $display("FAIL random_w4[%0d]: got %h expected %h", i,
                         {code2, cv2, ovr2, be2, avg2, avv2}, {m_code, m_cv, m_ovr, m_be, m_avg2, m_av2});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; therm = 15'h0000;
    model_reset();
    test_reset();
    test_directed();
    test_avg_window();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
